linear_layer_seq: RTL and testbench
===================================

// Module: linear_layer_seq
// PURPOSE
//  Time-multiplexed, parametrised fully-connected layer: y[i] = sat(round(b[i] + sum_j x[i..]*w[i][j])), optional ReLU.
//  One shared signed multiplier and a wide accumulator replace the fully-unrolled per-cycle layer.
//  Valid/ready on input and output, so layers chain into a pipelined SoH predictor.
//  Weights and biases are static ports; they must stay stable while busy=1.
// PARAMETERS
//  IN_SIZE   4   input vector length (>=1)
//  OUT_SIZE  64  output vector length (>=1)
//  DATA_W    32  signed fixed-point element width
//  FRAC      16  fractional bits of x, w, b and y (1..DATA_W-1)
//  ACC_W     72  accumulator width; must be >= 2*DATA_W + clog2(IN_SIZE) + 1
// PORTS
//  clk        in   1                     rising-edge clock
//  reset      in   1                     asynchronous, active-high reset
//  in_valid   in   1                     in_data/relu_en valid
//  in_ready   out  1                     block accepts a vector
//  in_data    in   IN_SIZE*DATA_W        x[j] at [j*DATA_W +: DATA_W]
//  relu_en    in   1                     apply ReLU to this vector's outputs
//  weights    in   OUT_SIZE*IN_SIZE*DATA_W  w[i][j] at [(i*IN_SIZE+j)*DATA_W +: DATA_W]
//  biases     in   OUT_SIZE*DATA_W       b[i] at [i*DATA_W +: DATA_W]
//  out_valid  out  1                     out_data holds a complete result vector
//  out_ready  in   1                     downstream consumes the result
//  out_data   out  OUT_SIZE*DATA_W       y[i] at [i*DATA_W +: DATA_W]
//  busy       out  1                     high in MAC or WRITE
//  sat_flag   out  1                     sticky: any y[i] of the current vector saturated
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; busy=0; sat_flag=0; out_data=0; counters i,j=0.
//  FSM states: IDLE, MAC, WRITE, DONE.
//   IDLE: in_ready=1. On in_valid&&in_ready edge:
//    latch x and relu_en; i=0; j=0; acc=sext(b[0])<<FRAC; sat_flag=0; go MAC.
//   MAC: each cycle acc += sext(x[j]*w[i][j]) (full 2*DATA_W product, no per-product shift).
//    j++. After j=IN_SIZE-1, go WRITE.
//   WRITE: r=(acc + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic).
//    Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if clipped set sat_flag.
//    If relu_en latched and result<0 -> 0. Write y[i].
//    If i=OUT_SIZE-1 go DONE; else i++, j=0, acc=sext(b[i+1])<<FRAC, go MAC.
//   DONE: out_valid=1; out_data and sat_flag held stable. On out_ready go IDLE (out_valid=0 next cycle).
//  in_ready is high only in IDLE. A new vector is never accepted in the same cycle a result is consumed.
//  Latency: out_valid rises OUT_SIZE*(IN_SIZE+1) cycles after the accepting edge.
//  Throughput: one vector per OUT_SIZE*(IN_SIZE+1)+2 cycles with out_ready tied high.
//  out_data is updated element-wise during WRITE. Only its value while out_valid=1 is defined.
//  in_data changes after acceptance have no effect. in_valid while not ready is ignored (held by source).
//  Reset mid-MAC/WRITE/DONE aborts: partial results discarded, out_data=0, no out_valid pulse.
//  Accumulator never wraps for legal ACC_W; saturation applies only at WRITE.
// TESTING (DATA_W=32, FRAC=16, IN_SIZE=2, OUT_SIZE=2 unless noted)
//  1 Basic: x=[1.0,2.0], w0=[0.5,0.25], w1=[-1.0,0], b=[0.125,0], relu_en=0
//    -> after 6 cycles out_valid; y0=0x00012000, y1=0xFFFF0000; sat_flag=0.
//  2 ReLU: same vector with relu_en=1 -> y0=0x00012000, y1=0x00000000.
//  3 Rounding (IN_SIZE=1,OUT_SIZE=1, b=0): x=0x00000001, w=0x00008000 -> y=0x00000001.
//    x=0xFFFFFFFF, same w -> y=0x00000000.
//  4 Saturation: x=[0x7FFF0000,0], w0=[0x7FFF0000,0], b=0
//    -> y0=0x7FFFFFFF, sat_flag=1; the next clean vector clears sat_flag.
//  5 Backpressure: hold out_ready=0 for 10 cycles in DONE
//    -> out_valid, out_data, sat_flag stable; in_ready=0; in_valid ignored.
//    Raise out_ready -> IDLE next cycle.
//  6 Reset mid-MAC (cycle 3 after accept) -> immediate IDLE, out_data=0, no out_valid.
//    A following vector gives the exact results of test 1.

Source files
------------

// File: rtl/linear_layer_seq.sv
// Time-multiplexed fully-connected layer: one shared signed MAC walks w[i][j] row by row,
// then rounds half-up, saturates and optionally applies ReLU when each y[i] is written back.
module linear_layer_seq #(
  parameter int IN_SIZE  = 4,
  parameter int OUT_SIZE = 64,
  parameter int DATA_W   = 32,
  parameter int FRAC     = 16,
  parameter int ACC_W    = 72
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_SIZE*DATA_W-1:0]           in_data,
  input  logic                                relu_en,
  input  logic [OUT_SIZE*IN_SIZE*DATA_W-1:0]  weights,
  input  logic [OUT_SIZE*DATA_W-1:0]          biases,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_SIZE*DATA_W-1:0]          out_data,
  output logic                                busy,
  output logic                                sat_flag
);

  localparam int IW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int JW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int PW = 2 * DATA_W;

  localparam logic [IW-1:0] I_ZERO = IW'(1'b0);
  localparam logic [IW-1:0] I_ONE  = IW'(1'b1);
  localparam logic [JW-1:0] J_ZERO = JW'(1'b0);
  localparam logic [JW-1:0] J_ONE  = JW'(1'b1);

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1'b1) <<< (FRAC-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [IN_SIZE*DATA_W-1:0]    x_q, x_d;
  logic                         relu_q, relu_d;
  logic [IW-1:0]                i_q, i_d;
  logic [JW-1:0]                j_q, j_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [OUT_SIZE*DATA_W-1:0]   y_q, y_d;
  logic                         sat_q, sat_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         busy_q, busy_d;

  logic [DATA_W-1:0]            x_sel_s, w_sel_s, b_sel_s;
  logic [IW-1:0]                b_idx_s;
  logic signed [PW-1:0]         prod_s;
  logic signed [ACC_W-1:0]      acc_init_s, rnd_s, shifted_s;
  logic [DATA_W-1:0]            y_res_s;
  logic                         y_clip_s;

  // Operand selection is written as a compare-and-keep scan so index widths never need to match array depths.
  function automatic logic [DATA_W-1:0] sel_x(input logic [IN_SIZE*DATA_W-1:0] vec,
                                              input logic [JW-1:0] j);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    for (int k = 0; k < IN_SIZE; k++) begin
      r = (k == int'(j)) ? vec[k*DATA_W +: DATA_W] : r;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sel_w(input logic [OUT_SIZE*IN_SIZE*DATA_W-1:0] vec,
                                              input logic [IW-1:0] i, input logic [JW-1:0] j);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) begin
      r = (k == int'(i)*IN_SIZE + int'(j)) ? vec[k*DATA_W +: DATA_W] : r;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sel_b(input logic [OUT_SIZE*DATA_W-1:0] vec,
                                              input logic [IW-1:0] i);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    for (int k = 0; k < OUT_SIZE; k++) begin
      r = (k == int'(i)) ? vec[k*DATA_W +: DATA_W] : r;
    end
    return r;
  endfunction

  function automatic logic [OUT_SIZE*DATA_W-1:0] upd_y(input logic [OUT_SIZE*DATA_W-1:0] vec,
                                                       input logic [IW-1:0] i,
                                                       input logic [DATA_W-1:0] val);
    logic [OUT_SIZE*DATA_W-1:0] r;
    r = vec;
    for (int k = 0; k < OUT_SIZE; k++) begin
      r[k*DATA_W +: DATA_W] = (k == int'(i)) ? val : vec[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // Shared datapath: operand fetch, full-width product, bias preload for the next row.
  assign x_sel_s    = sel_x(x_q, j_q);
  assign w_sel_s    = sel_w(weights, i_q, j_q);
  assign prod_s     = PW'($signed(x_sel_s)) * PW'($signed(w_sel_s));
  assign b_idx_s    = (state_q == ST_IDLE) ? I_ZERO : (i_q + I_ONE);
  assign b_sel_s    = sel_b(biases, b_idx_s);
  assign acc_init_s = ACC_W'($signed(b_sel_s)) <<< FRAC;
  assign rnd_s      = acc_q + HALF;
  assign shifted_s  = rnd_s >>> FRAC;

  // Write-back conversion: clip to the DATA_W range, then optional ReLU.
  always_comb begin
    y_res_s  = shifted_s[DATA_W-1:0];
    y_clip_s = 1'b0;
    if (shifted_s > Y_MAX) begin
      y_res_s  = Y_MAX[DATA_W-1:0];
      y_clip_s = 1'b1;
    end else if (shifted_s < Y_MIN) begin
      y_res_s  = Y_MIN[DATA_W-1:0];
      y_clip_s = 1'b1;
    end else begin
      y_clip_s = 1'b0;
    end
    if (relu_q && y_res_s[DATA_W-1]) begin
      y_res_s = {DATA_W{1'b0}};
    end else begin
      y_res_s = y_res_s;
    end
  end

  // Next-state and datapath update for the IDLE -> MAC/WRITE loop -> DONE sequence.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    relu_d  = relu_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    y_d     = y_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = in_data;
          relu_d  = relu_en;
          i_d     = I_ZERO;
          j_d     = J_ZERO;
          acc_d   = acc_init_s;
          sat_d   = 1'b0;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        if (int'(j_q) == IN_SIZE - 1) begin
          state_d = ST_WRITE;
        end else begin
          j_d = j_q + J_ONE;
        end
      end
      ST_WRITE: begin
        y_d   = upd_y(y_q, i_q, y_res_s);
        sat_d = sat_q | y_clip_s;
        if (int'(i_q) == OUT_SIZE - 1) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + I_ONE;
          j_d     = J_ZERO;
          acc_d   = acc_init_s;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_MAC) || (state_d == ST_WRITE);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= {(IN_SIZE*DATA_W){1'b0}};
      relu_q      <= 1'b0;
      i_q         <= I_ZERO;
      j_q         <= J_ZERO;
      acc_q       <= {ACC_W{1'b0}};
      y_q         <= {(OUT_SIZE*DATA_W){1'b0}};
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      relu_q      <= relu_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sat_flag  = sat_q;
  assign out_data  = y_q;

endmodule

// File: tb/tb_linear_layer_seq.sv
// Directed plus randomized bench for linear_layer_seq: a 2x2 instance and a 1x1 instance
// checked against an integer-arithmetic reference of the layer equation.
module tb_linear_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             a_rst, a_in_valid, a_in_ready, a_relu, a_out_valid, a_out_ready, a_busy, a_sat;
  logic [1:0][31:0] a_x, a_b, a_y;
  logic [3:0][31:0] a_w;
  logic             b_rst, b_in_valid, b_in_ready, b_relu, b_out_valid, b_out_ready, b_busy, b_sat;
  logic [31:0]      b_x, b_w, b_b, b_y;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [1:0][31:0] last_y;
  logic             last_sat;

  linear_layer_seq #(.IN_SIZE(2), .OUT_SIZE(2), .DATA_W(32), .FRAC(16), .ACC_W(72)) dut_a (
    .clk(clk), .reset(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_x),
    .relu_en(a_relu), .weights(a_w), .biases(a_b), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_y), .busy(a_busy), .sat_flag(a_sat));

  linear_layer_seq #(.IN_SIZE(1), .OUT_SIZE(1), .DATA_W(32), .FRAC(16), .ACC_W(72)) dut_b (
    .clk(clk), .reset(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_x),
    .relu_en(b_relu), .weights(b_w), .biases(b_b), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_y), .busy(b_busy), .sat_flag(b_sat));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic ov(input bit on_b);
    return on_b ? b_out_valid : a_out_valid;
  endfunction

  function automatic logic ir(input bit on_b);
    return on_b ? b_in_ready : a_in_ready;
  endfunction

  function automatic logic bz(input bit on_b);
    return on_b ? b_busy : a_busy;
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    v = $urandom;
    return 32'($signed(v) >>> $urandom_range(0, 20));
  endfunction

  // y[i] = sat(floor((b*2^16 + sum x*w + 2^15) / 2^16)), then ReLU if requested
  task automatic ref_model(input int ni, input int no, input logic [1:0][31:0] xs,
                           input logic [3:0][31:0] ws, input logic [1:0][31:0] bs,
                           input logic rl, output logic [1:0][31:0] ys, output logic sat);
    logic signed [127:0] acc, q;
    ys  = 64'd0;
    sat = 1'b0;
    for (int i = 0; i < no; i++) begin
      acc = $signed(bs[i]);
      acc = acc * 128'sd65536;
      for (int j = 0; j < ni; j++) begin
        acc = acc + $signed(xs[j]) * $signed(ws[i*ni+j]);
      end
      acc = acc + 128'sd32768;
      q = acc / 128'sd65536;
      if (acc < 128'sd0 && q * 128'sd65536 != acc) q = q - 128'sd1;
      if (q > 128'sd2147483647) begin
        q = 128'sd2147483647;
        sat = 1'b1;
      end else if (q < -128'sd2147483648) begin
        q = -128'sd2147483648;
        sat = 1'b1;
      end
      if (rl && q < 128'sd0) q = 128'sd0;
      ys[i] = q[31:0];
    end
  endtask

  task automatic run(input bit on_b, input string tag);
    logic [1:0][31:0] xs, bs, ey;
    logic [3:0][31:0] ws;
    logic rl, es;
    int n;
    if (on_b) begin
      xs = {32'd0, b_x}; ws = {96'd0, b_w}; bs = {32'd0, b_b}; rl = b_relu;
    end else begin
      xs = a_x; ws = a_w; bs = a_b; rl = a_relu;
    end
    ref_model(on_b ? 1 : 2, on_b ? 1 : 2, xs, ws, bs, rl, ey, es);
    check({tag, "_in_ready"}, 32'(ir(on_b)), 32'd1);
    if (on_b) b_in_valid = 1'b1; else a_in_valid = 1'b1;
    tick;
    if (on_b) begin
      b_in_valid = 1'b0; b_x = $urandom;
    end else begin
      a_in_valid = 1'b0; a_x = {$urandom, $urandom};
    end
    check({tag, "_busy"}, 32'(bz(on_b)), 32'd1);
    n = 0;
    while (!ov(on_b) && n < 100) begin
      tick;
      n++;
    end
    check({tag, "_latency"}, 32'(n), on_b ? 32'd2 : 32'd6);
    if (on_b) begin
      check({tag, "_y0"}, b_y, ey[0]);
      check({tag, "_sat"}, 32'(b_sat), 32'(es));
    end else begin
      check({tag, "_y0"}, a_y[0], ey[0]);
      check({tag, "_y1"}, a_y[1], ey[1]);
      check({tag, "_sat"}, 32'(a_sat), 32'(es));
    end
    last_y   = ey;
    last_sat = es;
  endtask

  task automatic consume(input bit on_b, input string tag);
    if (on_b) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    tick;
    if (on_b) b_out_ready = 1'b0; else a_out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(ov(on_b)), 32'd0);
    check({tag, "_idle_ready"}, 32'(ir(on_b)), 32'd1);
  endtask

  task automatic set_t1(input logic rl);
    a_x[0] = 32'h00010000; a_x[1] = 32'h00020000;
    a_w[0] = 32'h00008000; a_w[1] = 32'h00004000;
    a_w[2] = 32'hFFFF0000; a_w[3] = 32'h00000000;
    a_b[0] = 32'h00002000; a_b[1] = 32'h00000000;
    a_relu = rl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    a_rst = 1'b0; b_rst = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_relu = 1'b0; a_x = 64'd0; a_w = 128'd0; a_b = 64'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_relu = 1'b0; b_x = 32'd0; b_w = 32'd0; b_b = 32'd0;
    #2;
    a_rst = 1'b1; b_rst = 1'b1;
    #2;
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_sat", 32'(a_sat), 32'd0);
    check("rst_y0", a_y[0], 32'd0);
    check("rst_y1", a_y[1], 32'd0);
    check("rst_b_y", b_y, 32'd0);
    tick;
    a_rst = 1'b0; b_rst = 1'b0;
    tick;

    // basic and ReLU vectors
    set_t1(1'b0);
    run(1'b0, "t1");
    check("t1_y0_const", a_y[0], 32'h00012000);
    check("t1_y1_const", a_y[1], 32'hFFFF0000);
    consume(1'b0, "t1");
    set_t1(1'b1);
    run(1'b0, "t2");
    check("t2_y1_const", a_y[1], 32'h00000000);
    consume(1'b0, "t2");

    // rounding on the 1x1 instance
    b_x = 32'h00000001; b_w = 32'h00008000; b_b = 32'd0; b_relu = 1'b0;
    run(1'b1, "t3a");
    check("t3a_const", b_y, 32'h00000001);
    consume(1'b1, "t3a");
    b_x = 32'hFFFFFFFF; b_w = 32'h00008000; b_b = 32'd0;
    run(1'b1, "t3b");
    check("t3b_const", b_y, 32'h00000000);
    consume(1'b1, "t3b");

    // saturation, then a clean vector clears the sticky flag
    a_x = {32'd0, 32'h7FFF0000}; a_w = {96'd0, 32'h7FFF0000}; a_b = 64'd0; a_relu = 1'b0;
    run(1'b0, "t4");
    check("t4_y0_const", a_y[0], 32'h7FFFFFFF);
    check("t4_sat_const", 32'(a_sat), 32'd1);
    consume(1'b0, "t4");
    set_t1(1'b0);
    run(1'b0, "t4_clean");
    check("t4_clean_sat", 32'(a_sat), 32'd0);

    // backpressure: hold DONE with a competing in_valid
    a_in_valid = 1'b1;
    a_x = {32'h00050000, 32'h00030000};
    for (int c = 0; c < 10; c++) begin
      tick;
      check("t5_valid", 32'(a_out_valid), 32'd1);
      check("t5_y0", a_y[0], last_y[0]);
      check("t5_y1", a_y[1], last_y[1]);
      check("t5_sat", 32'(a_sat), 32'(last_sat));
      check("t5_in_ready", 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    tick;
    a_out_ready = 1'b0;
    a_in_valid = 1'b0;
    check("t5_release_ready", 32'(a_in_ready), 32'd1);
    check("t5_release_valid", 32'(a_out_valid), 32'd0);
    tick;
    check("t5_no_accept", 32'(a_busy), 32'd0);

    // reset mid-MAC aborts the vector
    set_t1(1'b0);
    a_in_valid = 1'b1;
    tick;
    a_in_valid = 1'b0;
    tick;
    tick;
    a_rst = 1'b1;
    #1;
    check("t6_in_ready", 32'(a_in_ready), 32'd1);
    check("t6_busy", 32'(a_busy), 32'd0);
    check("t6_out_valid", 32'(a_out_valid), 32'd0);
    check("t6_y0", a_y[0], 32'd0);
    check("t6_y1", a_y[1], 32'd0);
    tick;
    a_rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      seen = seen | a_out_valid;
    end
    check("t6_no_pulse", 32'(seen), 32'd0);
    set_t1(1'b0);
    run(1'b0, "t6_after");
    check("t6_after_y0", a_y[0], 32'h00012000);
    check("t6_after_y1", a_y[1], 32'hFFFF0000);
    consume(1'b0, "t6_after");

    // randomized vectors on both instances
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 2; k++) begin
        a_x[k] = rnd_val();
        a_b[k] = rnd_val();
      end
      for (int k = 0; k < 4; k++) a_w[k] = rnd_val();
      a_relu = 1'($urandom_range(0, 1));
      run(1'b0, "rand_a");
      consume(1'b0, "rand_a");
    end
    for (int r = 0; r < 6; r++) begin
      b_x = rnd_val(); b_w = rnd_val(); b_b = rnd_val();
      b_relu = 1'($urandom_range(0, 1));
      run(1'b1, "rand_b");
      consume(1'b1, "rand_b");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
